gpio_ctrl: RTL

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/sync_edge.sv | 30 +++
 rtl/gpio_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared register map, write-size encodings and the byte-lane merge helper.
package gpio_pkg;

  localparam logic [4:0] OFF_OUT     = 5'h00;
  localparam logic [4:0] OFF_SET     = 5'h04;
  localparam logic [4:0] OFF_CLR     = 5'h08;
  localparam logic [4:0] OFF_TGL     = 5'h0C;
  localparam logic [4:0] OFF_IN      = 5'h10;
  localparam logic [4:0] OFF_RISE_EN = 5'h14;
  localparam logic [4:0] OFF_FALL_EN = 5'h18;
  localparam logic [4:0] OFF_STATUS  = 5'h1C;

  typedef enum logic [1:0] {
    WR_BYTE = 2'b00,
    WR_HALF = 2'b01,
    WR_WORD = 2'b10,
    WR_NONE = 2'b11
  } wsize_e;

  localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

  // Replace only the lanes covered by the write size; keep the rest.
  function automatic logic [31:0] wr_merge(input logic [31:0] old_v,
                                           input logic [31:0] d,
                                           input logic [31:0] m);
    return (old_v & ~m) | (d & m);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Per-pin synchroniser chain plus history flop; flags rising/falling edges.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chain <= '0;
      r_hist  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
      r_hist  <= r_chain[STAGES-1];
    end
  end

  assign sync = r_chain[STAGES-1];
  assign rise = sync & ~r_hist;
  assign fall = ~sync & r_hist;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO block: output register with set/clear/toggle aliases, synchronised
// inputs with per-pin edge interrupts and a W1C status register.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_OUT     = 8,
  parameter int NUM_IN      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sel,
  input  logic [4:0]         addr,
  input  logic [1:0]         write_n,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic               irq
);

  logic [NUM_OUT-1:0] r_out;
  logic [NUM_IN-1:0]  r_rise_en;
  logic [NUM_IN-1:0]  r_fall_en;
  logic [NUM_IN-1:0]  r_status;
  logic               r_irq;

  logic [NUM_IN-1:0]  w_sync, w_rise, w_fall, w_evt, w_clr;
  logic [31:0]        w_mask, w_d;
  logic [31:0]        w_out_m, w_ren_m, w_fen_m;
  logic [4:0]         w_off;
  logic               w_we;
  logic               w_unused;

  assign w_unused = ^addr[1:0];
  assign w_off    = {addr[4:2], 2'b00};
  assign w_we     = sel && (write_n != WR_NONE);

  always_comb begin
    w_mask = 32'h0;
    case (write_n)
      WR_BYTE: w_mask = 32'h0000_00FF;
      WR_HALF: w_mask = 32'h0000_FFFF;
      WR_WORD: w_mask = 32'hFFFF_FFFF;
      default: w_mask = 32'h0;
    endcase
  end

  assign w_d     = data_in & w_mask;
  assign w_out_m = wr_merge(32'(r_out),     w_d, w_mask);
  assign w_ren_m = wr_merge(32'(r_rise_en), w_d, w_mask);
  assign w_fen_m = wr_merge(32'(r_fall_en), w_d, w_mask);

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    sync_edge #(.STAGES(SYNC_STAGES)) u_se (
      .clk  (clk),
      .rstn (rstn),
      .d    (gpio_in[g]),
      .sync (w_sync[g]),
      .rise (w_rise[g]),
      .fall (w_fall[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_we) begin
      case (w_off)
        OFF_OUT:     r_out     <= w_out_m[NUM_OUT-1:0];
        OFF_SET:     r_out     <= r_out |  w_d[NUM_OUT-1:0];
        OFF_CLR:     r_out     <= r_out & ~w_d[NUM_OUT-1:0];
        OFF_TGL:     r_out     <= r_out ^  w_d[NUM_OUT-1:0];
        OFF_RISE_EN: r_rise_en <= w_ren_m[NUM_IN-1:0];
        OFF_FALL_EN: r_fall_en <= w_fen_m[NUM_IN-1:0];
        default: ;
      endcase
    end
  end

  // New events are OR-ed in after the clear, so a same-cycle event survives W1C.
  assign w_evt = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr = (w_we && w_off == OFF_STATUS) ? w_d[NUM_IN-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_evt;
      r_irq    <= |r_status;
    end
  end

  always_comb begin
    data_out = RD_UNMAPPED;
    if (sel) begin
      case (w_off)
        OFF_OUT:     data_out = 32'(r_out);
        OFF_SET,
        OFF_CLR,
        OFF_TGL:     data_out = 32'h0;
        OFF_IN:      data_out = 32'(w_sync);
        OFF_RISE_EN: data_out = 32'(r_rise_en);
        OFF_FALL_EN: data_out = 32'(r_fall_en);
        OFF_STATUS:  data_out = 32'(r_status);
        default:     data_out = RD_UNMAPPED;
      endcase
    end
  end

  assign gpio_out = r_out;
  assign irq      = r_irq;

endmodule
